logic_clk_monitor: RTL and testbench
====================================

Name: logic_clk_monitor

Overview:
- Measures the divided clock that the programmable logic clock divider produces, downstream of that divider.
- Samples that clock as data in the master_clk domain and measures high time, low time and period in master_clk cycles.
- Counts rising edges and flags a stalled clock.
- Results go to the AXI register interface through a valid/ack handshake, so software can confirm the divider setting in hardware.

Parameters:
- COUNTER_BITS, 32, width of every measurement counter and result.
- SYNC_STAGES, 2, number of synchronizer flops on mon_in (minimum 2).

Ports:
- master_clk  in  1  sole clock.
- axi_resetn  in  1  asynchronous active-low reset.
- mon_in  in  1  clock under observation (divider output_clk), asynchronous to master_clk.
- enable  in  1  level; monitor runs while high.
- timeout_cycles  in  COUNTER_BITS  cycles without any edge before stall is flagged; 0 disables the timeout.
- result_ack  in  1  consumer has read the results.
- high_count  out  COUNTER_BITS  cycles mon_in was high in the last complete period.
- low_count  out  COUNTER_BITS  cycles mon_in was low in the last complete period.
- period_count  out  COUNTER_BITS  high_count+low_count, saturating.
- edge_count  out  COUNTER_BITS  rising edges seen since enable, saturating.
- result_valid  out  1  new results available.
- overrun  out  1  sticky; results were overwritten before being acked.
- stalled  out  1  no mon_in edge within timeout_cycles.

Behaviour:
- Reset: all outputs 0, state IDLE, synchronizer flops 0.
- Edge detection
  - mon_in passes SYNC_STAGES flops, then one history flop.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Latency from a mon_in edge to the detect cycle is SYNC_STAGES+1 cycles.
- States: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, STALL.
- IDLE
  - Internal counters and edge_count cleared; stalled cleared.
  - high/low/period, result_valid and overrun hold their values.
  - enable=1 -> WAIT_RISE.
- Any state with enable=0 -> IDLE on the next cycle (partial measurement discarded).
- WAIT_RISE: on rise -> MEAS_HIGH with hcnt=1. A fall here is ignored.
- MEAS_HIGH: hcnt increments each cycle; on fall -> MEAS_LOW with lcnt=1.
- MEAS_LOW: lcnt increments each cycle; on rise:
  - publish high_count=hcnt, low_count=lcnt, period_count=sat(hcnt+lcnt), set result_valid;
  - then hcnt=1 and return to MEAS_HIGH.
- Result registers update at the clock edge that ends the rise-detect cycle.
- Edge counting: every rise while enabled increments edge_count, including the first rise and the rise that exits STALL.
- Arithmetic
  - hcnt, lcnt and edge_count saturate at 2^COUNTER_BITS-1.
  - period is summed in COUNTER_BITS+1 bits, then clamped to 2^COUNTER_BITS-1.
- Timeout
  - idle_cnt clears on any rise or fall and increments otherwise (saturating).
  - Stall condition: timeout_cycles!=0 and idle_cnt reaches timeout_cycles in WAIT_RISE, MEAS_HIGH or MEAS_LOW.
  - On stall -> STALL and stalled=1; the partial measurement is discarded.
- STALL: on rise -> MEAS_HIGH with hcnt=1 and stalled=0; nothing is published.
- Handshake
  - result_ack=1 while result_valid=1 -> result_valid=0 and overrun=0 next cycle.
  - Publish while result_valid=1 and result_ack=0 -> overrun=1.
  - Publish and result_ack in the same cycle -> result_valid stays 1, overrun=0.
  - result_ack while result_valid=0 has no effect.
- Reset mid-measurement: asynchronous, all state returns to reset values immediately. mon_in glitches narrower than a cycle may be missed; no requirement on them.

Decomposition:
- Package logic_clk_monitor_pkg: state enum (IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, STALL) and a saturating-increment function parameterized by width.
- Sub-module logic_clk_sync: SYNC_STAGES synchronizer plus history flop, producing s, rise and fall. Clock and reset ports named as here.

Test Plan:
- Divide-by-4 (2 high / 2 low master_clk cycles), enable=1, timeout 0 -> first publish high=2, low=2, period=4, result_valid=1; edge_count=2 after the second rise.
- 3 high / 5 low pattern, ack each result -> every publish high=3, low=5, period=8; overrun stays 0.
- Same pattern with no ack over two periods -> overrun=1 after the second publish; one ack cycle -> result_valid=0, overrun=0.
- timeout_cycles=20, mon_in held low after one period -> stalled=1 exactly 20 cycles after the last detected edge; the next rise clears stalled with no publish, and the following full period publishes.
- Assert axi_resetn low in MEAS_LOW mid-period -> all outputs 0 immediately; after release, the first publish requires a full rise-fall-rise.
- Drop enable during MEAS_HIGH -> IDLE next cycle, edge_count=0, previous results and result_valid held; simultaneous publish+ack cycle -> result_valid remains 1.

Source files
------------

// File: rtl/logic_clk_monitor_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : logic_clk_monitor_pkg                                 |
// | Purpose  : Shared state encoding and saturating-count helper.    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package logic_clk_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RISE = 3'd1,
    MEAS_HIGH = 3'd2,
    MEAS_LOW  = 3'd3,
    STALL     = 3'd4
  } mon_state_e;

  localparam int unsigned SAT_MAX_W       = 64;
  localparam int          MIN_SYNC_STAGES = 2;

  // Callers zero-extend into SAT_MAX_W bits and truncate the result back to width.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int unsigned         width);
    logic [SAT_MAX_W-1:0] lim;
    if (width >= SAT_MAX_W) begin
      lim = '1;
    end else begin
      lim = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
    end
    if (val >= lim) begin
      return lim;
    end
    return val + SAT_MAX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_clk_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : logic_clk_sync                                        |
// | Purpose  : Synchronizes mon_i into master_clk, detects edges.    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module logic_clk_sync
  import logic_clk_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic master_clk,
  input  logic axi_resetn,
  input  logic mon_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge master_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], mon_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign s_o    = sync_q[STAGES-1];
  assign rise_o = s_o & ~hist_q;
  assign fall_o = ~s_o & hist_q;

endmodule
`default_nettype wire

// File: rtl/logic_clk_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : logic_clk_monitor                                     |
// | Purpose  : Measures high/low/period of the divided logic clock,  |
// |            counts rising edges, flags stalls, valid/ack results. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module logic_clk_monitor
  import logic_clk_monitor_pkg::*;
#(
  parameter int COUNTER_BITS = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    master_clk,
  input  logic                    axi_resetn,
  input  logic                    mon_in,
  input  logic                    enable,
  input  logic [COUNTER_BITS-1:0] timeout_cycles,
  input  logic                    result_ack,
  output logic [COUNTER_BITS-1:0] high_count,
  output logic [COUNTER_BITS-1:0] low_count,
  output logic [COUNTER_BITS-1:0] period_count,
  output logic [COUNTER_BITS-1:0] edge_count,
  output logic                    result_valid,
  output logic                    overrun,
  output logic                    stalled
);

  localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);

  function automatic logic [COUNTER_BITS-1:0] inc_sat(input logic [COUNTER_BITS-1:0] v);
    return COUNTER_BITS'(sat_inc(SAT_MAX_W'(v), COUNTER_BITS));
  endfunction

  logic mon_level_unused;
  logic rise;
  logic fall;

  logic_clk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .master_clk(master_clk),
    .axi_resetn(axi_resetn),
    .mon_i     (mon_in),
    .s_o       (mon_level_unused),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  mon_state_e              state_q;
  logic [COUNTER_BITS-1:0] hcnt_q;
  logic [COUNTER_BITS-1:0] lcnt_q;
  logic [COUNTER_BITS-1:0] idle_cnt_q;
  logic [COUNTER_BITS-1:0] edge_q;
  logic [COUNTER_BITS-1:0] high_q;
  logic [COUNTER_BITS-1:0] low_q;
  logic [COUNTER_BITS-1:0] period_q;
  logic                    valid_q;
  logic                    overrun_q;
  logic                    stalled_q;

  logic [COUNTER_BITS-1:0] idle_cnt_d;
  logic [COUNTER_BITS:0]   period_sum;
  logic [COUNTER_BITS-1:0] period_sat;
  logic                    any_edge;
  logic                    measuring;
  logic                    timed_out;
  logic                    publish;
  logic                    ack;

  always_comb begin
    any_edge   = rise | fall;
    idle_cnt_d = any_edge ? '0 : inc_sat(idle_cnt_q);
    measuring  = (state_q == WAIT_RISE) || (state_q == MEAS_HIGH) || (state_q == MEAS_LOW);
    timed_out  = measuring && (timeout_cycles != '0) && (idle_cnt_d >= timeout_cycles);
    period_sum = {1'b0, hcnt_q} + {1'b0, lcnt_q};
    period_sat = period_sum[COUNTER_BITS] ? CNT_MAX : period_sum[COUNTER_BITS-1:0];
    publish    = enable && (state_q == MEAS_LOW) && rise;
    ack        = result_ack && valid_q;
  end

  always_ff @(posedge master_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      idle_cnt_q <= '0;
      edge_q     <= '0;
      high_q     <= '0;
      low_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      stalled_q  <= 1'b0;
    end else begin
      // Result handshake runs independently of the measurement state.
      if (publish) begin
        high_q   <= hcnt_q;
        low_q    <= lcnt_q;
        period_q <= period_sat;
        valid_q  <= 1'b1;
        if (valid_q) begin
          overrun_q <= ~result_ack;
        end
      end else if (ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      if (!enable || (state_q == IDLE)) begin
        hcnt_q     <= '0;
        lcnt_q     <= '0;
        idle_cnt_q <= '0;
        edge_q     <= '0;
        stalled_q  <= 1'b0;
        state_q    <= enable ? WAIT_RISE : IDLE;
      end else begin
        idle_cnt_q <= idle_cnt_d;
        if (rise) begin
          edge_q <= inc_sat(edge_q);
        end
        case (state_q)
          WAIT_RISE: begin
            if (rise) begin
              hcnt_q  <= CNT_ONE;
              state_q <= MEAS_HIGH;
            end else if (timed_out) begin
              stalled_q <= 1'b1;
              state_q   <= STALL;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              lcnt_q  <= CNT_ONE;
              state_q <= MEAS_LOW;
            end else if (timed_out) begin
              hcnt_q    <= '0;
              lcnt_q    <= '0;
              stalled_q <= 1'b1;
              state_q   <= STALL;
            end else begin
              hcnt_q <= inc_sat(hcnt_q);
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              hcnt_q  <= CNT_ONE;
              lcnt_q  <= '0;
              state_q <= MEAS_HIGH;
            end else if (timed_out) begin
              hcnt_q    <= '0;
              lcnt_q    <= '0;
              stalled_q <= 1'b1;
              state_q   <= STALL;
            end else begin
              lcnt_q <= inc_sat(lcnt_q);
            end
          end
          STALL: begin
            if (rise) begin
              hcnt_q    <= CNT_ONE;
              lcnt_q    <= '0;
              stalled_q <= 1'b0;
              state_q   <= MEAS_HIGH;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign high_count   = high_q;
  assign low_count    = low_q;
  assign period_count = period_q;
  assign edge_count   = edge_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;
  assign stalled      = stalled_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_clk_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_logic_clk_monitor                                  |
// | Purpose  : Randomized bench for logic_clk_monitor with an        |
// |            edge-timestamp reference model.                       |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_logic_clk_monitor;

  localparam int     CB   = 32;
  localparam int     NS   = 2;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  localparam int M_OFF   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_HIGH  = 2;
  localparam int M_LOW   = 3;
  localparam int M_STALL = 4;

  logic          master_clk = 1'b0;
  logic          axi_resetn;
  logic          mon_in;
  logic          enable;
  logic [CB-1:0] timeout_cycles;
  logic          result_ack;
  logic [CB-1:0] high_count;
  logic [CB-1:0] low_count;
  logic [CB-1:0] period_count;
  logic [CB-1:0] edge_count;
  logic          result_valid;
  logic          overrun;
  logic          stalled;

  logic_clk_monitor #(
    .COUNTER_BITS(CB),
    .SYNC_STAGES (NS)
  ) dut (
    .master_clk    (master_clk),
    .axi_resetn    (axi_resetn),
    .mon_in        (mon_in),
    .enable        (enable),
    .timeout_cycles(timeout_cycles),
    .result_ack    (result_ack),
    .high_count    (high_count),
    .low_count     (low_count),
    .period_count  (period_count),
    .edge_count    (edge_count),
    .result_valid  (result_valid),
    .overrun       (overrun),
    .stalled       (stalled)
  );

  always #5 master_clk = ~master_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: measurements are differences of edge timestamps.
  int     m_mode;
  longint cyc;
  longint t_rise, t_fall, t_ref;
  longint e_high, e_low, e_period, e_edges;
  bit     e_valid, e_ov, e_stalled;
  bit     hist[$];

  task automatic model_reset();
    m_mode = M_OFF;
    t_rise = 0; t_fall = 0; t_ref = 0;
    e_high = 0; e_low = 0; e_period = 0; e_edges = 0;
    e_valid = 0; e_ov = 0; e_stalled = 0;
    hist = {};
    for (int i = 0; i < NS + 1; i++) hist.push_back(1'b0);
  endtask

  // mon_in level seen by the monitor at the coming edge is the one driven NS edges earlier.
  function automatic bit seen_rise();
    return hist[hist.size()-NS] && !hist[hist.size()-NS-1];
  endfunction

  function automatic bit seen_fall();
    return !hist[hist.size()-NS] && hist[hist.size()-NS-1];
  endfunction

  function automatic bit will_publish();
    return enable && (m_mode == M_LOW) && seen_rise();
  endfunction

  task automatic model_step();
    bit rz, fl, pub, stall;
    longint h, l;
    cyc++;
    rz = seen_rise();
    fl = seen_fall();
    pub = 0; h = 0; l = 0;
    if (!enable) begin
      m_mode = M_OFF; e_edges = 0; e_stalled = 0;
    end else if (m_mode == M_OFF) begin
      m_mode = M_WAIT; t_ref = cyc; e_edges = 0; e_stalled = 0;
    end else begin
      if (rz) e_edges = (e_edges + 1 > CMAX) ? CMAX : e_edges + 1;
      stall = (timeout_cycles != 0) && !(rz || fl) && ((cyc - t_ref) >= longint'(timeout_cycles))
              && (m_mode == M_WAIT || m_mode == M_HIGH || m_mode == M_LOW);
      if (rz || fl) t_ref = cyc;
      case (m_mode)
        M_WAIT:  if (rz) begin m_mode = M_HIGH; t_rise = cyc; end
                 else if (stall) begin m_mode = M_STALL; e_stalled = 1; end
        M_HIGH:  if (fl) begin m_mode = M_LOW; t_fall = cyc; end
                 else if (stall) begin m_mode = M_STALL; e_stalled = 1; end
        M_LOW:   if (rz) begin
                   pub = 1;
                   h = t_fall - t_rise; l = cyc - t_fall;
                   t_rise = cyc; m_mode = M_HIGH;
                 end else if (stall) begin m_mode = M_STALL; e_stalled = 1; end
        M_STALL: if (rz) begin m_mode = M_HIGH; t_rise = cyc; e_stalled = 0; end
        default: m_mode = M_OFF;
      endcase
    end
    if (pub) begin
      if (e_valid) e_ov = !result_ack;
      e_valid  = 1;
      e_high   = (h > CMAX) ? CMAX : h;
      e_low    = (l > CMAX) ? CMAX : l;
      e_period = (e_high + e_low > CMAX) ? CMAX : e_high + e_low;
    end else if (result_ack && e_valid) begin
      e_valid = 0; e_ov = 0;
    end
    hist.push_back(mon_in);
    if (hist.size() > NS + 2) void'(hist.pop_front());
  endtask

  task automatic compare_all();
    check_value("high_count",   high_count,   e_high);
    check_value("low_count",    low_count,    e_low);
    check_value("period_count", period_count, e_period);
    check_value("edge_count",   edge_count,   e_edges);
    check_value("result_valid", result_valid, e_valid);
    check_value("overrun",      overrun,      e_ov);
    check_value("stalled",      stalled,      e_stalled);
  endtask

  // Stimulus generator state.
  int pat_hi = 2, pat_lo = 2, pat_pos = 0;
  bit rand_pat = 0;
  int hold_cnt = 0;
  bit hold_val = 0;
  int ack_mode = 0;

  task automatic step();
    if (hold_cnt > 0) begin
      mon_in = hold_val;
      hold_cnt--;
    end else begin
      mon_in = (pat_pos < pat_hi);
      pat_pos++;
      if (pat_pos >= pat_hi + pat_lo) begin
        pat_pos = 0;
        if (rand_pat) begin
          pat_hi = $urandom_range(1, 9);
          pat_lo = $urandom_range(1, 9);
        end
      end
    end
    case (ack_mode)
      0:       result_ack = 1'b0;
      1:       result_ack = 1'b1;
      2:       result_ack = ($urandom_range(0, 3) == 0);
      default: result_ack = will_publish();
    endcase
    @(posedge master_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic step_until_mode(input int mode, input int budget, input string tag);
    int n = 0;
    while (m_mode != mode && n < budget) begin
      step();
      n++;
    end
    check_value(tag, m_mode, mode);
  endtask

  task automatic pulse_reset(input int n);
    #3 axi_resetn = 1'b0;
    model_reset();
    #1;
    compare_all();
    check_value("rst_async_valid", result_valid, 0);
    repeat (n) @(posedge master_clk);
    #1 axi_resetn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    cyc = 0;
    axi_resetn = 1'b0;
    mon_in = 1'b0;
    enable = 1'b0;
    timeout_cycles = '0;
    result_ack = 1'b0;
    model_reset();
    @(posedge master_clk);
    #1;
    compare_all();
    @(posedge master_clk);
    #1 axi_resetn = 1'b1;

    // Divide-by-4
    enable = 1'b1;
    pat_hi = 2; pat_lo = 2; pat_pos = 0;
    n = 0;
    while (!e_valid && n < 30) begin step(); n++; end
    check_value("div4_high", high_count, 2);
    check_value("div4_low", low_count, 2);
    check_value("div4_period", period_count, 4);
    check_value("div4_valid", result_valid, 1);
    check_value("div4_edges", edge_count, 2);
    repeat (10) step();

    // 3 high / 5 low, every result acknowledged
    ack_mode = 1;
    pat_hi = 3; pat_lo = 5; pat_pos = 0;
    repeat (60) step();
    check_value("p35_high", high_count, 3);
    check_value("p35_low", low_count, 5);
    check_value("p35_period", period_count, 8);
    check_value("p35_overrun", overrun, 0);

    // No ack over two periods, then a single ack
    ack_mode = 0;
    repeat (20) step();
    check_value("noack_overrun", overrun, 1);
    n = 0;
    while (will_publish() && n < 4) begin step(); n++; end
    ack_mode = 1;
    step();
    ack_mode = 0;
    check_value("ack_valid_clr", result_valid, 0);
    check_value("ack_overrun_clr", overrun, 0);

    // Stall detection with timeout 20
    timeout_cycles = 20;
    ack_mode = 1;
    n = 0;
    while (pat_pos != 0 && n < 20) begin step(); n++; end
    repeat (8) step();
    hold_val = 1'b0; hold_cnt = 45;
    n = 0; seen = 0;
    while (n < 60 && !seen) begin
      step();
      n++;
      if (stalled) seen = 1;
    end
    check_value("stall_seen", stalled, 1);
    check_value("stall_delay", cyc - t_ref, 20);
    step_until_mode(M_HIGH, 40, "stall_exit_mode");
    check_value("stall_exit", stalled, 0);
    check_value("stall_no_pub", result_valid, 0);
    ack_mode = 0;
    n = 0;
    while (!e_valid && n < 20) begin step(); n++; end
    check_value("post_stall_high", high_count, 3);
    check_value("post_stall_low", low_count, 5);

    // Reset in MEAS_LOW
    timeout_cycles = 0;
    ack_mode = 2;
    step_until_mode(M_LOW, 20, "reach_low");
    step();
    pulse_reset(2);
    repeat (30) step();

    // Drop enable in MEAS_HIGH; then a publish coinciding with ack
    ack_mode = 0;
    n = 0;
    while (!e_valid && n < 30) begin step(); n++; end
    step_until_mode(M_HIGH, 20, "reach_high");
    enable = 1'b0;
    step();
    check_value("endrop_edges", edge_count, 0);
    check_value("endrop_valid", result_valid, 1);
    enable = 1'b1;
    ack_mode = 3;
    n = 0; seen = 0;
    while (n < 40 && !seen) begin
      if (will_publish() && e_valid) begin
        step();
        check_value("pub_ack_valid", result_valid, 1);
        check_value("pub_ack_overrun", overrun, 0);
        seen = 1;
      end else begin
        step();
      end
      n++;
    end

    // Randomized traffic
    rand_pat = 1;
    ack_mode = 2;
    timeout_cycles = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(4, 16);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0)
        timeout_cycles = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(4, 16);
      if (hold_cnt == 0 && $urandom_range(0, 49) == 0) begin
        hold_val = 1'($urandom_range(0, 1));
        hold_cnt = $urandom_range(5, 30);
      end
      if (i == 400) pulse_reset(1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
